// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one word read/write per request, stall held until completion.
// Optional sticky protocol-error flag err_o is built only when DMEM_ERR_EN is defined.
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 3
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
`ifdef DMEM_ERR_EN
    output logic              err_o,
`endif
    output logic              stall_o
);

    // state | meaning
    // IDLE  | waiting for a request; LATENCY=1 accesses complete here
    // BUSY  | request latched, cnt_q counting down to the access edge
    typedef enum logic {IDLE, BUSY} state_t;

    localparam int  DEPTH  = 2 ** ADDR_W;
    localparam bit  SINGLE = (LATENCY == 1);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              stall_q;
`ifdef DMEM_ERR_EN
    logic              err_q;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              req;
    logic              fire;
    logic              fire_we;
    logic [ADDR_W-1:0] fire_addr;
    logic [DATA_W-1:0] fire_wdata;

    assign req = read_i | write_i;

    // Single-cycle memory acts straight on the inputs; otherwise on the latched request.
    always_comb begin
        fire       = 1'b0;
        fire_we    = 1'b0;
        fire_addr  = addr_q;
        fire_wdata = wdata_q;
        if (SINGLE) begin
            fire       = (state_q == IDLE) && req;
            fire_we    = write_i;
            fire_addr  = addr_i;
            fire_wdata = wdata_i;
        end else begin
            fire       = (state_q == BUSY) && (cnt_q == 4'd1);
            fire_we    = we_q;
        end
    end

    // Array is deliberately not reset; reset only blocks a commit.
    always_ff @(posedge clk_i) begin
        if (fire && fire_we && reset_ni) begin
            mem_q[fire_addr] <= fire_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            stall_q  <= 1'b0;
`ifdef DMEM_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q    <= write_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
`ifdef DMEM_ERR_EN
                        if (read_i && write_i) err_q <= 1'b1;
`endif
                        if (!SINGLE) begin
                            cnt_q   <= 4'(LATENCY - 1);
                            stall_q <= 1'b1;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
`ifdef DMEM_ERR_EN
                    if (req) err_q <= 1'b1;
`endif
                    if (cnt_q == 4'd1) begin
                        stall_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (fire && !fire_we) begin
                rdata_q  <= mem_q[fire_addr];
                rvalid_q <= 1'b1;
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign stall_o  = stall_q;
`ifdef DMEM_ERR_EN
    assign err_o    = err_q;
`endif

endmodule
